// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment width, hex glyph table and pin polarity helper.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    // Active-high {g,f,e,d,c,b,a} glyphs for 0..F
    localparam logic [SEG_W-1:0] SEG7_HEX_LUT [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    function automatic logic [SEG_W-1:0] polarity_apply(input logic [SEG_W-1:0] pattern,
                                                        input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high seven-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] pattern
);

    assign pattern = SEG7_HEX_LUT[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex seven-segment scanner with frame-synchronous value update.
// Optional leading-zero suppression: define HEX_DISPLAY_LEADING_ZERO_BLANK_EN.
module hex_display_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  value_valid,
    input  logic                  blank,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [SEG_W-1:0]  SEG_OFF  = polarity_apply({SEG_W{1'b0}}, SEG_ACTIVE_LOW);
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pending_q, active_q, active_d;
    logic                tick, wrap;
    logic [3:0]          nibble;
    logic                dp_sel, shown;
    logic [DIGITS-1:0]   an_onehot;
    logic [SEG_W-1:0]    pattern;
    logic [SEG_W-1:0]    seg_d;
    logic                dp_d;
    logic [DIGITS-1:0]   an_d;

    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        wrap     = tick && (idx_q == IDX_LAST);
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // A load landing on the wrap cycle bypasses pending so it shows next frame
        active_d = active_q;
        if (wrap) begin
            active_d = value_valid ? value_in : pending_q;
        end
    end

    always_comb begin
        nibble    = '0;
        dp_sel    = 1'b0;
        an_onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nibble       = active_q[4*k +: 4];
                dp_sel       = dp_in[k];
                an_onehot[k] = 1'b1;
            end
        end
    end

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msn;

    always_comb begin
        msn = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (active_q[4*k +: 4] != 4'h0) begin
                msn = IDX_W'(k);
            end
        end
        shown = (idx_q <= msn);
    end
`else
    assign shown = 1'b1;
`endif

    hex_to_seg7 u_hex_to_seg7 (
        .nibble  (nibble),
        .pattern (pattern)
    );

    always_comb begin
        seg_d = shown ? polarity_apply(pattern, SEG_ACTIVE_LOW) : SEG_OFF;
        dp_d  = dp_sel ^ SEG_ACTIVE_LOW;
        an_d  = blank ? AN_OFF : (an_onehot ^ AN_OFF);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pending_q  <= '0;
            active_q   <= '0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            if (value_valid) begin
                pending_q <= value_in;
            end
            seg        <= seg_d;
            dp         <= dp_d;
            an         <= an_d;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (DIGITS=8, REFRESH_DIV=4, active-low pins).
module tb_hex_display_scanner;

    localparam int D = 8;
    localparam int R = 4;
    localparam int P = R * D;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    value_in = '0;
    logic           value_valid = 1'b0;
    logic           blank = 1'b0;
    logic [7:0]     dp_in = '0;
    logic [6:0]     seg;
    logic           dp;
    logic [7:0]     an;
    logic           frame_done;

    int checks = 0;
    int errors = 0;

    hex_display_scanner #(
        .DIGITS         (D),
        .REFRESH_DIV    (R),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .value_valid (value_valid),
        .blank       (blank),
        .dp_in       (dp_in),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] g [16] = '{
            7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
        };
        return g[h];
    endfunction

    // Reference model: everything derived from n, the number of clock edges since reset release.
    int          n = 0;
    logic [31:0] latest = '0;
    logic [31:0] shown = '0;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [7:0]  exp_an = 8'hFF;
    logic        exp_fd = 1'b0;

    always @(posedge clk or negedge rst) begin
        int d;
        int msn;
        if (!rst) begin
            n = 0; latest = '0; shown = '0;
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 8'hFF; exp_fd = 1'b0;
        end else begin
            n = n + 1;
            d = ((n - 1) / R) % D;
            msn = 0;
            for (int k = 0; k < D; k++) if (shown[4*k +: 4] != 4'h0) msn = k;
            exp_seg = ~glyph(shown[4*d +: 4]);
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
            if (d > msn) exp_seg = 7'h7F;
`endif
            exp_dp = ~dp_in[d];
            exp_an = blank ? 8'hFF : ~(8'h01 << d);
            if (value_valid) latest = value_in;
            exp_fd = (n % P == 0);
            if (exp_fd) shown = latest;
        end
    end

    always @(negedge clk) begin
        check("scan", {an, seg, dp, frame_done}, {exp_an, exp_seg, exp_dp, exp_fd});
    end

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg_al;
    } lut_vec_t;

    lut_vec_t tbl [16];

    task automatic wait_fd();
        bit seen = 0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        check("frame_done_timeout", 64'(seen), 64'd1);
    endtask

    task automatic wait_digit(input int dig);
        bit hit = 0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (((n % P) / R) == dig) begin
                hit = 1;
                break;
            end
        end
        check("digit_timeout", 64'(hit), 64'd1);
    endtask

    task automatic wait_phase(input int ph);
        bit hit = 0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if ((n % P) == ph) begin
                hit = 1;
                break;
            end
        end
        check("phase_timeout", 64'(hit), 64'd1);
    endtask

    initial begin
        bit found;
        tbl = '{
            '{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
            '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
            '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
            '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}
        };

        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        found = 0;
        for (int i = 0; i < R + 1; i++) begin
            @(posedge clk);
            #1;
            if (an == 8'hFE) begin
                found = 1;
                break;
            end
        end
        check("first_digit", 64'(found), 64'd1);

        // Glyph table, observed on digit 0 of the frame after the load
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            value_in = {8{tbl[i].nib}};
            value_valid = 1'b1;
            @(negedge clk);
            value_valid = 1'b0;
            wait_fd();
            @(posedge clk);
            #1;
            check("lut", {an, seg}, {8'hFE, tbl[i].seg_al});
        end

        // Mixed digits for a full frame
        @(negedge clk);
        value_in = 32'h0123_4567; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        wait_fd();
        wait_fd();

        // Tear-free: load mid-frame at digit 3
        value_in = 32'h1111_1111; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        wait_fd();
        wait_digit(3);
        value_in = 32'h2222_2222; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        wait_digit(7);
        @(posedge clk);
        #1;
        check("tear_free_old", {an, seg}, {8'h7F, 7'h79});
        wait_fd();
        wait_fd();

        // Load exactly on the wrap cycle
        wait_phase(P - 1);
        value_in = 32'h89AB_CDEF; value_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        value_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_bypass", {an, seg}, {8'hFE, 7'h0E});

        // Blank and decimal point
        @(negedge clk);
        dp_in = 8'h04;
        wait_fd();
        blank = 1'b1;
        repeat (10) @(negedge clk);
        blank = 1'b0;
        wait_fd();
        dp_in = 8'h00;

        // Leading zeros (suppressed when the optional feature is built in)
        value_in = 32'h0000_00A0; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        wait_fd();
        wait_fd();
        value_in = 32'h0; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        wait_fd();
        wait_fd();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            value_valid = ($urandom_range(0, 15) == 0);
            value_in = $urandom;
            if ($urandom_range(0, 7) == 0) value_in[31:16] = 16'h0;
            if ($urandom_range(0, 29) == 0) blank = ~blank;
            if ($urandom_range(0, 19) == 0) dp_in = 8'($urandom);
        end
        @(negedge clk);
        value_valid = 1'b0; blank = 1'b0;

        // Asynchronous reset mid-scan at digit 5
        wait_digit(5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", {an, seg, dp, frame_done}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_zero", {an, seg}, {8'hFE, 7'h40});
        repeat (2 * P) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
